// File: rtl/lsu_pkg.sv
// Shared definitions for the LSU memory master: funct3 codes, FSM states and
// the request legality check.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RMW_RD = 3'd2,
    WRITE  = 3'd3,
    RESP   = 3'd4
  } lsu_state_t;

  // Illegal funct3 or misaligned address for the requested access size.
  function automatic logic f3_err(input logic store, input logic [2:0] f3,
                                  input logic [1:0] lo);
    logic err;
    err = 1'b0;
    case (f3)
      F3_B, F3_BU: err = 1'b0;
      F3_H, F3_HU: err = lo[0];
      F3_W:        err = (lo != 2'b00);
      default:     err = 1'b1;
    endcase
    if (store && (f3 > F3_W)) err = 1'b1;
    return err;
  endfunction

endpackage

// File: rtl/lsu_mem_master_if.sv
// Core request/response and data-memory port bundle for lsu_mem_master.
interface lsu_mem_master_if #(
  parameter int unsigned ADDR_W = 32
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_store;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              MemRead;
  logic              MemWrite;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport master (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           MemRead, MemWrite, mem_addr, mem_wdata
  );

  modport slave (
    output req_valid, req_store, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           MemRead, MemWrite, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Combinational lane handling: load byte/half extract with sign/zero extend,
// and byte/half merge of store data into a read word.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[7:0];
    case (addr_lo)
      2'd0: byte_sel = word[7:0];
      2'd1: byte_sel = word[15:8];
      2'd2: byte_sel = word[23:16];
      2'd3: byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase
    half_sel = addr_lo[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    load_data = word;
    case (funct3)
      F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_data = {24'd0, byte_sel};
      F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_data = {16'd0, half_sel};
      default: load_data = word;
    endcase
  end

  always_comb begin
    store_word = word;
    case (funct3)
      F3_B:    store_word[{addr_lo, 3'b000} +: 8] = wdata[7:0];
      F3_H: begin
        if (addr_lo[1]) store_word[31:16] = wdata[15:0];
        else            store_word[15:0]  = wdata[15:0];
      end
      default: store_word = wdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator driving a word-wide data memory; sub-word stores are
// read-modify-write. Optional LSU_RANGE_CHECK_EN flags addresses >= MEM_BYTES.
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 128,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  lsu_mem_master_if.master bus
);

  if ((MEM_BYTES & (MEM_BYTES - 1)) != 0) begin : g_mem_bytes_check
    $error("MEM_BYTES must be a power of two");
  end

  lsu_state_t        state;
  logic              req_ready_q;
  logic              rsp_valid_q;
  logic              rsp_err_q;
  logic [31:0]       rsp_rdata_q;
  logic              mem_read_q;
  logic              mem_write_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic [2:0]        f3_q;
  logic [1:0]        lo_q;
  logic [31:0]       wdata_q;

  logic              req_err;
  logic [31:0]       load_data;
  logic [31:0]       store_word;

  always_comb begin
    req_err = f3_err(bus.req_store, bus.req_funct3, bus.req_addr[1:0]);
`ifdef LSU_RANGE_CHECK_EN
    if (bus.req_addr >= ADDR_W'(MEM_BYTES)) req_err = 1'b1;
`endif
  end

  lsu_lane_align u_align (
    .funct3     (f3_q),
    .addr_lo    (lo_q),
    .word       (bus.mem_rdata),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .store_word (store_word)
  );

  // Memory strobes are flops set on state entry, so they never glitch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      f3_q        <= '0;
      lo_q        <= '0;
      wdata_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid && req_ready_q) begin
            f3_q        <= bus.req_funct3;
            lo_q        <= bus.req_addr[1:0];
            wdata_q     <= bus.req_wdata;
            mem_addr_q  <= {bus.req_addr[ADDR_W-1:2], 2'b00};
            req_ready_q <= 1'b0;
            if (req_err) begin
              state       <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
            end else if (!bus.req_store) begin
              state      <= LOAD;
              mem_read_q <= 1'b1;
            end else if (bus.req_funct3 == F3_W) begin
              state       <= WRITE;
              mem_write_q <= 1'b1;
              mem_wdata_q <= bus.req_wdata;
            end else begin
              state      <= RMW_RD;
              mem_read_q <= 1'b1;
            end
          end
        end
        LOAD: begin
          state       <= RESP;
          mem_read_q  <= 1'b0;
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= 1'b0;
          rsp_rdata_q <= load_data;
        end
        RMW_RD: begin
          state       <= WRITE;
          mem_read_q  <= 1'b0;
          mem_write_q <= 1'b1;
          mem_wdata_q <= store_word;
        end
        WRITE: begin
          state       <= RESP;
          mem_write_q <= 1'b0;
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= 1'b0;
          rsp_rdata_q <= '0;
        end
        RESP: begin
          state       <= IDLE;
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b1;
        end
        default: begin
          state       <= IDLE;
          req_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
          mem_read_q  <= 1'b0;
          mem_write_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.MemRead   = mem_read_q;
  assign bus.MemWrite  = mem_write_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Scoreboard bench for lsu_mem_master: directed requests push expected
// responses; a negedge monitor checks data, error, latency and memory traffic.
module tb_lsu_mem_master;
  import lsu_pkg::*;

  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned MEM_BYTES = 128;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          n_rd;
    int          n_wr;
    logic [31:0] wa;
    logic [31:0] wd;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lsu_mem_master_if #(.ADDR_W(ADDR_W)) bus ();

  lsu_mem_master #(.MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] mem [MEM_BYTES/4];
  logic        poke_en  = 1'b0;
  logic [4:0]  poke_idx = '0;
  logic [31:0] poke_val = '0;

  assign bus.mem_rdata = mem[bus.mem_addr[6:2]];

  always @(negedge clk) begin
    if (poke_en) mem[poke_idx] <= poke_val;
    else if (bus.MemWrite) mem[bus.mem_addr[6:2]] <= bus.mem_wdata;
  end

  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   tests = 0;
  int   fails = 0;
  exp_t q[$];
  int   n_rd = 0;
  int   n_wr = 0;
  int   wr_total = 0;
  logic [31:0] wa_seen = '0;
  logic [31:0] wd_seen = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.MemWrite) wr_total++;
    if (rst) begin
      n_rd = 0;
      n_wr = 0;
    end else begin
      if (bus.MemRead) n_rd++;
      if (bus.MemWrite) begin
        n_wr++;
        wa_seen = bus.mem_addr;
        wd_seen = bus.mem_wdata;
      end
      if (bus.rsp_valid) begin
        if (q.size() == 0) begin
          check("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("rsp_rdata", bus.rsp_rdata, e.rdata);
          check("rsp_err", {31'd0, bus.rsp_err}, {31'd0, e.err});
          check("latency", 32'(cyc - e.acc), 32'(e.lat));
          check("memread_cycles", 32'(n_rd), 32'(e.n_rd));
          check("memwrite_cycles", 32'(n_wr), 32'(e.n_wr));
          if (e.n_wr > 0) begin
            check("mem_addr_wr", wa_seen, e.wa);
            check("mem_wdata_wr", wd_seen, e.wd);
          end
        end
        n_rd = 0;
        n_wr = 0;
      end
    end
  end

  task automatic poke(input int idx, input logic [31:0] v);
    @(posedge clk); #1;
    poke_en  = 1'b1;
    poke_idx = 5'(idx);
    poke_val = v;
    @(posedge clk); #1;
    poke_en  = 1'b0;
  endtask

  task automatic drive(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output logic ok, output int acc);
    ok  = 1'b0;
    acc = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      check("req_ready_timeout", 32'd0, 32'd1);
    end else begin
      bus.req_valid  = 1'b1;
      bus.req_store  = st;
      bus.req_funct3 = f3;
      bus.req_addr   = a;
      bus.req_wdata  = wd;
      acc = cyc;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
    end
  endtask

  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] e_rdata,
                       input logic e_err, input int e_lat, input int e_rd,
                       input int e_wr, input logic [31:0] e_wa, input logic [31:0] e_wd);
    logic ok;
    int   acc;
    exp_t e;
    e.rdata = e_rdata; e.err = e_err; e.lat = e_lat; e.n_rd = e_rd; e.n_wr = e_wr;
    e.wa = e_wa; e.wd = e_wd; e.acc = 0;
    // Queue entry is pushed at the accept cycle so the monitor never races it.
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        bus.req_valid  = 1'b1;
        bus.req_store  = st;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        e.acc = cyc;
        q.push_back(e);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        return;
      end
    end
    ok  = 1'b0;
    acc = 0;
    check("req_ready_timeout", {31'd0, ok}, 32'd1 + 32'(acc));
  endtask

  task automatic drain();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (q.size() == 0) return;
    end
    check("drain_timeout", 32'(q.size()), 32'd0);
  endtask

  initial begin
    logic ok;
    int   acc;
    int   wr_before;
    bus.req_valid  = 1'b0;
    bus.req_store  = 1'b0;
    bus.req_funct3 = '0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;

    poke(4, 32'h807F_0201);
    poke(0, 32'hCAFE_0001);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_req_ready", {31'd0, bus.req_ready}, 32'd1);
    check("reset_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("reset_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
    check("reset_rsp_rdata", bus.rsp_rdata, 32'd0);
    check("reset_memread", {31'd0, bus.MemRead}, 32'd0);
    check("reset_memwrite", {31'd0, bus.MemWrite}, 32'd0);
    check("reset_mem_addr", bus.mem_addr, 32'd0);
    check("reset_mem_wdata", bus.mem_wdata, 32'd0);

    // Loads over 0x807F_0201 at 0x10
    issue(1'b0, F3_B,  32'h13, 32'h0, 32'hFFFF_FF80, 1'b0, 2, 1, 0, '0, '0);
    issue(1'b0, F3_BU, 32'h13, 32'h0, 32'h0000_0080, 1'b0, 2, 1, 0, '0, '0);
    issue(1'b0, F3_H,  32'h12, 32'h0, 32'hFFFF_807F, 1'b0, 2, 1, 0, '0, '0);
    issue(1'b0, F3_HU, 32'h10, 32'h0, 32'h0000_0201, 1'b0, 2, 1, 0, '0, '0);
    issue(1'b0, F3_B,  32'h11, 32'h0, 32'h0000_0002, 1'b0, 2, 1, 0, '0, '0);
    issue(1'b0, F3_W,  32'h10, 32'h0, 32'h807F_0201, 1'b0, 2, 1, 0, '0, '0);
    drain();

    poke(4, 32'h1122_3344);
    issue(1'b1, F3_B, 32'h11, 32'h0000_00AA, 32'h0, 1'b0, 3, 1, 1, 32'h10, 32'h1122_AA44);
    drain();
    check("mem_after_sb", mem[4], 32'h1122_AA44);
    poke(4, 32'h1122_3344);
    issue(1'b1, F3_H, 32'h12, 32'h0000_BEEF, 32'h0, 1'b0, 3, 1, 1, 32'h10, 32'hBEEF_3344);

    issue(1'b1, F3_W, 32'h20, 32'hDEAD_BEEF, 32'h0, 1'b0, 2, 0, 1, 32'h20, 32'hDEAD_BEEF);
    issue(1'b0, F3_W, 32'h20, 32'h0, 32'hDEAD_BEEF, 1'b0, 2, 1, 0, '0, '0);

    // Illegal / misaligned: no memory traffic, 1-cycle error response
    issue(1'b0, F3_W,  32'h22, 32'h0, 32'h0, 1'b1, 1, 0, 0, '0, '0);
    issue(1'b0, F3_H,  32'h21, 32'h0, 32'h0, 1'b1, 1, 0, 0, '0, '0);
    issue(1'b0, 3'd3,  32'h10, 32'h0, 32'h0, 1'b1, 1, 0, 0, '0, '0);
    issue(1'b1, F3_BU, 32'h10, 32'h5, 32'h0, 1'b1, 1, 0, 0, '0, '0);
    issue(1'b1, F3_W,  32'h21, 32'h5, 32'h0, 1'b1, 1, 0, 0, '0, '0);
    issue(1'b1, F3_H,  32'h13, 32'h5, 32'h0, 1'b1, 1, 0, 0, '0, '0);
`ifdef LSU_RANGE_CHECK_EN
    issue(1'b0, F3_W, 32'h80, 32'h0, 32'h0, 1'b1, 1, 0, 0, '0, '0);
`else
    issue(1'b0, F3_W, 32'h80, 32'h0, 32'hCAFE_0001, 1'b0, 2, 1, 0, '0, '0);
`endif
    drain();
    check("mem_after_sh", mem[4], 32'hBEEF_3344);
    check("mem_after_sw", mem[8], 32'hDEAD_BEEF);

    // Reset during RMW_RD of an SB drops the write
    poke(4, 32'h1122_3344);
    wr_before = wr_total;
    drive(1'b1, F3_B, 32'h11, 32'h0000_0055, ok, acc);
    check("abort_in_rmw_rd_memread", {31'd0, bus.MemRead}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_req_ready", {31'd0, bus.req_ready}, 32'd1);
    check("abort_memwrite", {31'd0, bus.MemWrite}, 32'd0);
    check("abort_memread", {31'd0, bus.MemRead}, 32'd0);
    repeat (4) @(negedge clk);
    check("abort_write_count", 32'(wr_total - wr_before), 32'd0);
    check("abort_mem_unchanged", mem[4], 32'h1122_3344);

    issue(1'b0, F3_W, 32'h10, 32'h0, 32'h1122_3344, 1'b0, 2, 1, 0, '0, '0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
- CPU-side load/store initiator that drives the data memory port: MemRead, MemWrite, address and write data.
- Accepts one load or store per request from the execute stage.
- Performs word-aligned accesses. Byte and halfword stores are done as read-modify-write, because the memory always writes 4 bytes.
- Sign- or zero-extends load data and returns a single-cycle response pulse.

Parameters:
- MEM_BYTES, 128, size of the attached data memory in bytes (power of 2).
- ADDR_W, 32, address width on both the core and memory sides.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  core request strobe.
- req_ready  output  1  high only in IDLE; a request is accepted when req_valid & req_ready.
- req_store  input  1  1 = store, 0 = load.
- req_funct3  input  3  RV32I funct3: LB 0, LH 1, LW 2, LBU 4, LHU 5; SB 0, SH 1, SW 2.
- req_addr  input  ADDR_W  byte address.
- req_wdata  input  32  store data, right-aligned.
- rsp_valid  output  1  one-cycle completion pulse.
- rsp_rdata  output  32  extended load data; 0 for stores and errors.
- rsp_err  output  1  valid with rsp_valid; misaligned access or illegal funct3.
- MemRead  output  1  memory read enable.
- MemWrite  output  1  memory write enable; memory commits on the falling edge.
- mem_addr  output  ADDR_W  always word-aligned: {addr[ADDR_W-1:2],2'b00}.
- mem_wdata  output  32  full word written to memory.
- mem_rdata  input  32  combinational read data from memory.

Behaviour:
- Reset (rst=1 at a rising edge):
  - state goes to IDLE; all registered fields clear.
  - req_ready=1; rsp_valid=0, rsp_err=0, rsp_rdata=0.
  - MemRead=0, MemWrite=0, mem_addr=0, mem_wdata=0.
- Reset mid-operation aborts the access. No MemWrite is asserted after the reset edge, so a half-done RMW is dropped.
- MemRead and MemWrite decode from the state register and are glitch-free relative to clk.
- States: IDLE, LOAD, RMW_RD, WRITE, RESP.
- IDLE, on accept, latches the request and checks it:
  - Error: funct3 in {3,6,7}; store with funct3>2; halfword with addr[0]=1; word with addr[1:0]!=0. Error → RESP with err=1 and no memory access.
  - Load → LOAD.
  - SW → WRITE with mem_wdata=req_wdata.
  - SB/SH → RMW_RD.
- LOAD: MemRead=1. Capture mem_rdata at the rising edge, select lane by addr[1:0], extend per funct3 → RESP.
- RMW_RD: MemRead=1. Capture the word, replace byte lane addr[1:0] (SB) or half lane addr[1] (SH) with wdata[7:0]/[15:0] → WRITE.
- WRITE: MemWrite=1 with merged or full word → RESP.
- RESP: rsp_valid=1 for exactly one cycle → IDLE. rsp_rdata and rsp_err hold until the next RESP.
- Latency from the accept edge to the rsp_valid cycle:
  - Error: 1 cycle.
  - Load and SW: 2 cycles.
  - SB/SH: 3 cycles.
- req_valid while req_ready=0 is ignored; the core must hold the request.
- Lane rules:
  - LB/LBU take byte addr[1:0].
  - LH/LHU take half addr[1].
  - Bit 7 or bit 15 is sign-extended for LB/LH only.
- Back-to-back requests: a new accept is possible in the IDLE cycle right after RESP, so there are no bubbles beyond the state sequence.

Optional Feature:
- Macro: LSU_RANGE_CHECK_EN.
- Defined: any address with req_addr >= MEM_BYTES is an error. The block responds as for a misaligned access, with no memory access.
- Undefined: high address bits pass through unchanged; the memory aliases them on its low address bits.

Decomposition:
- Shared package lsu_pkg holds:
  - funct3 localparams F3_B=0, F3_H=1, F3_W=2, F3_BU=4, F3_HU=5.
  - State encoding IDLE..RESP (3-bit).
- One natural sub-module, lsu_lane_align (combinational). It does load extract/extend and store merge from (funct3, addr[1:0], word, wdata); it is reused by LOAD and RMW_RD.

Test Plan:
- Memory word at 0x10 = 0x807F_0201:
  - LB at 0x13 → rsp_rdata=0xFFFF_FF80, rsp 2 cycles after accept.
  - LBU at 0x13 → 0x0000_0080.
  - LH at 0x12 → 0xFFFF_807F.
- SB 0xAA to 0x11 with word 0x1122_3344 at 0x10 → one MemRead cycle, then one MemWrite cycle with mem_addr=0x10 and mem_wdata=0x1122_AA44. rsp_valid at accept+3, rsp_err=0.
- SH 0xBEEF to 0x12 over 0x1122_3344 → mem_wdata=0xBEEF_3344.
- SW 0xDEAD_BEEF to 0x20 → no MemRead, MemWrite for one cycle; a following LW at 0x20 returns 0xDEAD_BEEF.
- Misaligned and illegal requests never assert MemRead or MemWrite; each gives rsp_valid at accept+1 with rsp_err=1:
  - LW at 0x22.
  - LH at 0x21.
  - funct3=3.
- Reset: assert rst in the RMW_RD cycle of an SB → MemWrite never asserts, memory unchanged, req_ready=1 the cycle after reset.
- With LSU_RANGE_CHECK_EN defined, LW at 0x80 → rsp_err=1. Without it, the memory access proceeds.
